// File: rtl/ppi_bus_master.sv
// Host-side sequencer for an 8255 PPI: turns single-cycle valid/ready
// requests into timed CS_N / RD_N / WR_N bus cycles, returns read data and
// stretches the PPI RESET pin to a programmable minimum width.
module ppi_bus_master #(
    parameter int SETUP_CYC   = 1,
    parameter int PULSE_CYC   = 3,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2,
    parameter int RST_CYC     = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_WRITE,
    input  logic [1:0] REQ_ADDR,
    input  logic [7:0] REQ_WDATA,
    output logic       RSP_VALID,
    output logic       RSP_WRITE,
    output logic [7:0] RSP_RDATA,
    output logic       PPI_RESET,
    output logic       CS_N,
    output logic       RD_N,
    output logic       WR_N,
    output logic [1:0] A,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    input  logic [7:0] DATA_IN
);

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // One shared down-counter must hold the longest phase length without wrapping.
    localparam int MAX_CYC = imax(imax(imax(SETUP_CYC, PULSE_CYC), imax(HOLD_CYC, RECOVER_CYC)), RST_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        ST_RST_WAIT = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SETUP    = 3'd2,
        ST_STROBE   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_RECOVER  = 3'd5
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             wr_r;
    logic             ready_r;
    logic             rsp_valid_r;
    logic             rsp_write_r;
    logic [7:0]       rsp_rdata_r;
    logic             ppi_reset_r;
    logic             cs_n_r;
    logic             rd_n_r;
    logic             wr_n_r;
    logic [1:0]       a_r;
    logic [7:0]       data_out_r;
    logic             data_oe_r;
    logic             cnt_last_s;

    // A timed state ends on the edge where the counter shows its final cycle.
    assign cnt_last_s = (cnt_r == CNT_W'(1));

    // Bus sequencer: every pin is a register so no request input reaches the bus combinationally.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_RST_WAIT;
            cnt_r       <= CNT_W'(RST_CYC);
            wr_r        <= 1'b0;
            ready_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_rdata_r <= 8'h00;
            ppi_reset_r <= 1'b1;
            cs_n_r      <= 1'b1;
            rd_n_r      <= 1'b1;
            wr_n_r      <= 1'b1;
            a_r         <= 2'b00;
            data_out_r  <= 8'h00;
            data_oe_r   <= 1'b0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_RST_WAIT: begin
                    if (cnt_last_s) begin
                        state_r     <= ST_IDLE;
                        ppi_reset_r <= 1'b0;
                        ready_r     <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    // A and DATA_OUT double as the latched address and write data.
                    if (REQ_VALID && ready_r) begin
                        state_r    <= ST_SETUP;
                        cnt_r      <= CNT_W'(SETUP_CYC);
                        wr_r       <= REQ_WRITE;
                        a_r        <= REQ_ADDR;
                        data_out_r <= REQ_WDATA;
                        data_oe_r  <= REQ_WRITE;
                        cs_n_r     <= 1'b0;
                        ready_r    <= 1'b0;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt_last_s) begin
                        state_r <= ST_STROBE;
                        cnt_r   <= CNT_W'(PULSE_CYC);
                        rd_n_r  <= wr_r;
                        wr_n_r  <= ~wr_r;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    // Read data is captured on the edge that closes the strobe.
                    if (cnt_last_s) begin
                        state_r     <= ST_HOLD;
                        cnt_r       <= CNT_W'(HOLD_CYC);
                        rd_n_r      <= 1'b1;
                        wr_n_r      <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        rsp_write_r <= wr_r;
                        if (!wr_r) begin
                            rsp_rdata_r <= DATA_IN;
                        end else begin
                            rsp_rdata_r <= rsp_rdata_r;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_last_s) begin
                        state_r   <= ST_RECOVER;
                        cnt_r     <= CNT_W'(RECOVER_CYC);
                        cs_n_r    <= 1'b1;
                        data_oe_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RECOVER: begin
                    if (cnt_last_s) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a full PPI reset sequence.
                    state_r     <= ST_RST_WAIT;
                    cnt_r       <= CNT_W'(RST_CYC);
                    ppi_reset_r <= 1'b1;
                    cs_n_r      <= 1'b1;
                    rd_n_r      <= 1'b1;
                    wr_n_r      <= 1'b1;
                    data_oe_r   <= 1'b0;
                    ready_r     <= 1'b0;
                end
            endcase
        end
    end

    assign REQ_READY = ready_r;
    assign RSP_VALID = rsp_valid_r;
    assign RSP_WRITE = rsp_write_r;
    assign RSP_RDATA = rsp_rdata_r;
    assign PPI_RESET = ppi_reset_r;
    assign CS_N      = cs_n_r;
    assign RD_N      = rd_n_r;
    assign WR_N      = wr_n_r;
    assign A         = a_r;
    assign DATA_OUT  = data_out_r;
    assign DATA_OE   = data_oe_r;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Scoreboard bench for ppi_bus_master: instance 0 uses default timing,
// instance 1 uses SETUP=2 PULSE=1 HOLD=2 RECOVER=1.
module tb_ppi_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset     [2];
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_write [2];
    logic [1:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic       rsp_write [2];
    logic [7:0] rsp_rdata [2];
    logic       ppi_reset [2];
    logic       cs_n      [2];
    logic       rd_n      [2];
    logic       wr_n      [2];
    logic [1:0] a         [2];
    logic [7:0] data_out  [2];
    logic       data_oe   [2];
    logic [7:0] data_in   [2] = '{8'hFF, 8'hFF};

    typedef struct packed {
        logic       wr;
        logic [7:0] rd;
    } rsp_t;

    rsp_t       q0 [$];
    rsp_t       q1 [$];
    int         rsp_cnt [2] = '{0, 0};
    logic [7:0] last_rd [2] = '{8'h00, 8'h00};
    logic [7:0] rd_byte = 8'h00;
    int         n_checks = 0;
    int         n_errors = 0;

    ppi_bus_master dut0 (
        .CLK(clk), .RESET(reset[0]), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
        .REQ_WRITE(req_write[0]), .REQ_ADDR(req_addr[0]), .REQ_WDATA(req_wdata[0]),
        .RSP_VALID(rsp_valid[0]), .RSP_WRITE(rsp_write[0]), .RSP_RDATA(rsp_rdata[0]),
        .PPI_RESET(ppi_reset[0]), .CS_N(cs_n[0]), .RD_N(rd_n[0]), .WR_N(wr_n[0]), .A(a[0]),
        .DATA_OUT(data_out[0]), .DATA_OE(data_oe[0]), .DATA_IN(data_in[0])
    );

    ppi_bus_master #(
        .SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(2), .RECOVER_CYC(1), .RST_CYC(4)
    ) dut1 (
        .CLK(clk), .RESET(reset[1]), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
        .REQ_WRITE(req_write[1]), .REQ_ADDR(req_addr[1]), .REQ_WDATA(req_wdata[1]),
        .RSP_VALID(rsp_valid[1]), .RSP_WRITE(rsp_write[1]), .RSP_RDATA(rsp_rdata[1]),
        .PPI_RESET(ppi_reset[1]), .CS_N(cs_n[1]), .RD_N(rd_n[1]), .WR_N(wr_n[1]), .A(a[1]),
        .DATA_OUT(data_out[1]), .DATA_OE(data_oe[1]), .DATA_IN(data_in[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int sel, input logic wr, input logic [7:0] rd);
        rsp_t e;
        e.wr = wr;
        e.rd = rd;
        if (sel == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // PPI side: drives the read byte only while RD_N is low, a floating-bus 0xFF otherwise
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) data_in[i] = (rd_n[i] === 1'b0) ? rd_byte : 8'hFF;
    end

    // Response monitor and bus-protocol watch for both instances
    always @(negedge clk) begin
        rsp_t e;
        for (int i = 0; i < 2; i++) begin
            if (rsp_valid[i] === 1'b1) begin
                rsp_cnt[i]++;
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp dut%0d: got write=%0b rdata=0x%02h, required no response",
                             i, rsp_write[i], rsp_rdata[i]);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    check($sformatf("rsp_write dut%0d", i), 32'(rsp_write[i]), 32'(e.wr));
                    check($sformatf("rsp_rdata dut%0d", i), 32'(rsp_rdata[i]), 32'(e.rd));
                end
            end
            check($sformatf("strobes_exclusive dut%0d", i), 32'(rd_n[i] | wr_n[i]), 32'd1);
            check($sformatf("strobe_inside_cs dut%0d", i), 32'(cs_n[i] & ~(rd_n[i] & wr_n[i])), 32'd0);
            check($sformatf("oe_inside_cs dut%0d", i), 32'(cs_n[i] & data_oe[i]), 32'd0);
        end
    end

    // One complete access; sample k=0 is the first cycle after the accepting edge
    task automatic run_access(input int sel, input logic wr, input logic [1:0] addr, input logic [7:0] wd,
                              input int exp_first, input int exp_pulse, input int exp_cs, input int exp_ready);
        int   guard = 0;
        int   k = 0;
        int   cs_low = 0;
        int   strb_first = -1;
        int   strb_len = 0;
        int   ready_k = -1;
        int   rsp_start;
        logic active;
        while (req_ready[sel] !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_before_access", 32'(req_ready[sel]), 32'd1);
        req_valid[sel] = 1'b1;
        req_write[sel] = wr;
        req_addr[sel]  = addr;
        req_wdata[sel] = wd;
        push_exp(sel, wr, wr ? last_rd[sel] : rd_byte);
        if (!wr) last_rd[sel] = rd_byte;
        rsp_start = rsp_cnt[sel];
        tick();
        // Garbage on the request lines must not disturb the latched access.
        req_valid[sel] = 1'b0;
        req_write[sel] = ~wr;
        req_addr[sel]  = ~addr;
        req_wdata[sel] = ~wd;
        while (ready_k < 0 && k < 30) begin
            check("a_held", 32'(a[sel]), 32'(addr));
            if (cs_n[sel] === 1'b0) begin
                cs_low++;
                check("data_oe_during_cs", 32'(data_oe[sel]), 32'(wr));
                if (wr) check("data_out_during_write", 32'(data_out[sel]), 32'(wd));
            end else begin
                check("data_oe_cs_high", 32'(data_oe[sel]), 32'd0);
            end
            active = wr ? ~wr_n[sel] : ~rd_n[sel];
            check("other_strobe_high", 32'(wr ? rd_n[sel] : wr_n[sel]), 32'd1);
            if (active === 1'b1) begin
                if (strb_first < 0) strb_first = k;
                strb_len++;
            end
            if (req_ready[sel] === 1'b1) begin
                ready_k = k;
            end else begin
                tick();
                k++;
            end
        end
        check("cs_low_cycles", 32'(cs_low), 32'(exp_cs));
        check("strobe_first_cycle", 32'(strb_first), 32'(exp_first));
        check("strobe_low_cycles", 32'(strb_len), 32'(exp_pulse));
        check("ready_return_cycles", 32'(ready_k), 32'(exp_ready));
        check("one_response", 32'(rsp_cnt[sel] - rsp_start), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_hi;
        int guard;
        int k;
        int rise_k;
        int fall_k;
        int start;
        logic acc2;
        logic go;
        logic take;

        for (int i = 0; i < 2; i++) begin
            reset[i]     = 1'b1;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 2'b00;
            req_wdata[i] = 8'h00;
        end

        // Power-up: three reset cycles, then PPI_RESET stretched by four more.
        repeat (3) tick();
        check("rst_ppi_reset", 32'(ppi_reset[0]), 32'd1);
        check("rst_cs_n", 32'(cs_n[0]), 32'd1);
        check("rst_rd_n", 32'(rd_n[0]), 32'd1);
        check("rst_wr_n", 32'(wr_n[0]), 32'd1);
        check("rst_a", 32'(a[0]), 32'd0);
        check("rst_data_out", 32'(data_out[0]), 32'd0);
        check("rst_data_oe", 32'(data_oe[0]), 32'd0);
        check("rst_req_ready", 32'(req_ready[0]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_rsp_write", 32'(rsp_write[0]), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata[0]), 32'd0);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        n_hi = 0;
        guard = 0;
        while (ppi_reset[0] === 1'b1 && guard < 20) begin
            check("powerup_strobes_high", 32'({cs_n[0], rd_n[0], wr_n[0]}), 32'd7);
            check("powerup_not_ready", 32'(req_ready[0]), 32'd0);
            n_hi++;
            guard++;
            tick();
        end
        check("ppi_reset_width", 32'(n_hi), 32'd4);
        check("ready_at_ppi_reset_fall", 32'(req_ready[0]), 32'd1);

        // Control-word write, then a port B read with data changing in HOLD.
        run_access(0, 1'b1, 2'b11, 8'h80, 1, 3, 5, 7);
        rd_byte = 8'h5A;
        run_access(0, 1'b0, 2'b01, 8'h00, 1, 3, 5, 7);

        // Back-to-back: REQ_VALID stays high, a write then a read.
        guard = 0;
        while (req_ready[0] !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 2'b10;
        req_wdata[0] = 8'h3C;
        push_exp(0, 1'b1, last_rd[0]);
        start = rsp_cnt[0];
        tick();
        req_write[0] = 1'b0;
        req_addr[0]  = 2'b00;
        req_wdata[0] = 8'h11;
        rd_byte = 8'hC3;
        push_exp(0, 1'b0, 8'hC3);
        last_rd[0] = 8'hC3;
        k = 0;
        rise_k = -1;
        fall_k = -1;
        acc2 = 1'b0;
        go = 1'b1;
        while (go && k < 40) begin
            if (cs_n[0] === 1'b1 && rise_k < 0) rise_k = k;
            if (cs_n[0] === 1'b0 && rise_k >= 0 && fall_k < 0) fall_k = k;
            if (acc2 && req_ready[0] === 1'b1) begin
                go = 1'b0;
            end else begin
                take = (req_ready[0] === 1'b1) && (req_valid[0] === 1'b1);
                tick();
                k++;
                if (take) begin
                    req_valid[0] = 1'b0;
                    acc2 = 1'b1;
                end
            end
        end
        check("b2b_second_accepted", 32'(acc2), 32'd1);
        check("b2b_first_cs_rise", 32'(rise_k), 32'd5);
        check("b2b_cs_gap_at_least_2", 32'(fall_k - rise_k >= 2), 32'd1);
        check("b2b_two_responses", 32'(rsp_cnt[0] - start), 32'd2);

        // Reset during the second WR_N-low cycle drops the access.
        guard = 0;
        while (req_ready[0] !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 2'b11;
        req_wdata[0] = 8'h9B;
        start = rsp_cnt[0];
        tick();
        req_valid[0] = 1'b0;
        tick();
        check("mid_first_wr_low", 32'(wr_n[0]), 32'd0);
        tick();
        check("mid_second_wr_low", 32'(wr_n[0]), 32'd0);
        reset[0] = 1'b1;
        tick();
        check("mid_rst_wr_n", 32'(wr_n[0]), 32'd1);
        check("mid_rst_cs_n", 32'(cs_n[0]), 32'd1);
        check("mid_rst_data_oe", 32'(data_oe[0]), 32'd0);
        check("mid_rst_ppi_reset", 32'(ppi_reset[0]), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        reset[0] = 1'b0;
        last_rd[0] = 8'h00;
        repeat (6) tick();
        check("mid_rst_no_response", 32'(rsp_cnt[0] - start), 32'd0);
        run_access(0, 1'b1, 2'b00, 8'hA5, 1, 3, 5, 7);

        // Alternate timing on the second instance.
        run_access(1, 1'b1, 2'b10, 8'hA5, 2, 1, 5, 6);
        rd_byte = 8'h96;
        run_access(1, 1'b0, 2'b01, 8'h00, 2, 1, 5, 6);

        repeat (3) tick();
        check("scoreboard0_drained", 32'(q0.size()), 32'd0);
        check("scoreboard1_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ppi_bus_master.md
Name: ppi_bus_master

Overview:
Synchronous host-side sequencer that sits directly upstream of the 8255 PPI block. It converts a single-cycle valid/ready request interface into correctly timed asynchronous 8255 bus cycles on CS_N, RD_N, WR_N, A and the data bus, and returns read data. It also generates the PPI's RESET pulse with a programmable minimum width.

Parameters:
SETUP_CYC, 1, cycles CS_N/A/data are valid before the strobe asserts (>=1)
PULSE_CYC, 3, cycles RD_N or WR_N is held low (>=1)
HOLD_CYC, 1, cycles CS_N/A/data are held after the strobe deasserts (>=1)
RECOVER_CYC, 2, cycles with CS_N high before the next access (>=1)
RST_CYC, 4, cycles PPI_RESET is held high after RESET deasserts (>=1)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
REQ_VALID  input  1  host request valid
REQ_READY  output  1  block can accept a request
REQ_WRITE  input  1  1 = write cycle, 0 = read cycle
REQ_ADDR  input  2  PPI register select (00 A, 01 B, 10 C, 11 control)
REQ_WDATA  input  8  write data
RSP_VALID  output  1  one-cycle pulse: access complete
RSP_WRITE  output  1  type of the completed access, valid with RSP_VALID
RSP_RDATA  output  8  read data, valid with RSP_VALID when RSP_WRITE=0
PPI_RESET  output  1  drives the PPI RESET pin
CS_N  output  1  PPI chip select, active low
RD_N  output  1  PPI read strobe, active low
WR_N  output  1  PPI write strobe, active low
A  output  2  PPI address
DATA_OUT  output  8  data driven toward the PPI
DATA_OE  output  1  1 = DATA_OUT drives the shared bus (tristate built at top level)
DATA_IN  input  8  shared bus value as seen from the PPI

Behaviour:
- Reset: one clock, synchronous active-high RESET. While RESET=1: state=RST_WAIT, counter loaded with RST_CYC; PPI_RESET=1, CS_N=1, RD_N=1, WR_N=1, A=00, DATA_OUT=00, DATA_OE=0, REQ_READY=0, RSP_VALID=0, RSP_WRITE=0, RSP_RDATA=00.
- All bus outputs are registered; no combinational path from REQ_* to bus pins.
- States: RST_WAIT, IDLE, SETUP, STROBE, HOLD, RECOVER. One down-counter is shared by all timed states.
- RST_WAIT: PPI_RESET=1 for RST_CYC cycles after RESET falls, then IDLE with PPI_RESET=0.
- IDLE: REQ_READY=1 (only state with REQ_READY=1). On REQ_VALID&&REQ_READY:
  - latch WRITE/ADDR/WDATA;
  - next cycle enter SETUP with CS_N=0, A=addr, DATA_OE=write, DATA_OUT=wdata.
- SETUP: lasts SETUP_CYC cycles, then STROBE.
- STROBE: RD_N=0 (read) or WR_N=0 (write) for PULSE_CYC cycles. For reads, DATA_IN is sampled on the clock edge that ends the last STROBE cycle.
- HOLD: both strobes high, CS_N/A/DATA_OE/DATA_OUT unchanged, lasts HOLD_CYC cycles.
  - RSP_VALID=1 for exactly the first HOLD cycle; RSP_WRITE=latched type.
  - RSP_RDATA=sampled byte on reads; RSP_RDATA is unchanged on writes.
- RECOVER: CS_N=1, DATA_OE=0, A holds its last value, lasts RECOVER_CYC cycles, then IDLE.
- Timing per access: acceptance to REQ_READY high again is SETUP_CYC+PULSE_CYC+HOLD_CYC+RECOVER_CYC cycles (defaults: 7). Back-to-back requests are therefore separated by at least that many cycles.
- RD_N and WR_N are never low simultaneously. No strobe is low while CS_N=1. DATA_OE=1 only during write SETUP/STROBE/HOLD.
- REQ_* changes outside IDLE are ignored; the latched copy is used for the whole access.
- RESET mid-access: the next edge forces RST_WAIT and the reset values above. The in-flight access is dropped and no RSP_VALID is issued for it.
- Counter width: wide enough for max(parameters); no wrap-around inside a state.

Test Plan:
- Power-up: hold RESET 3 cycles, release -> PPI_RESET stays 1 for exactly 4 more cycles, REQ_READY rises the cycle PPI_RESET falls, all strobes high throughout.
- Control write: REQ_WRITE=1, ADDR=11, WDATA=0x80 -> CS_N low 5 cycles, WR_N low cycles 2-4 of those, A=11 and DATA_OUT=0x80 with DATA_OE=1 across all 5, RSP_VALID once with RSP_WRITE=1, REQ_READY back after 7 cycles.
- Port read: ADDR=01, DATA_IN=0x5A during STROBE and changed to 0xFF in HOLD -> RD_N low 3 cycles, DATA_OE=0 throughout, RSP_VALID with RSP_RDATA=0x5A.
- Back-to-back: REQ_VALID held high with write then read queued -> second CS_N fall no earlier than 2 cycles after first CS_N rise, exactly two RSP_VALID pulses.
- Reset mid-strobe: assert RESET during second WR_N-low cycle -> next edge WR_N=1, CS_N=1, DATA_OE=0, PPI_RESET=1, no RSP_VALID.
- Parameter sweep SETUP=2, PULSE=1, HOLD=2, RECOVER=1: write -> WR_N low 1 cycle after 2 setup cycles, CS_N low 5 cycles total, REQ_READY returns after 6 cycles.
